// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// Top-level optional feature macro: BRU_STATS_EN.
package bru_pkg;
  localparam int BRU_IDX_W = 10;
  localparam int BRU_PC_W  = 32;
  localparam int PC_INCR   = 4;

  // Entry layout for the default configuration (PC_W=32, IDX_W=10).
  typedef struct packed {
    logic [BRU_PC_W-1:0]  pc;
    logic [BRU_IDX_W-1:0] idx;
    logic                 pred_taken;
    logic [BRU_PC_W-1:0]  pred_target;
  } bru_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;
endpackage

// File: rtl/bru_fifo.sv
// Circular queue of in-flight branches; pointers carry an extra wrap bit.
module bru_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
endmodule

// File: rtl/branch_resolve_unit.sv
// Pops predicted branches as EX resolves them, trains the predictor and
// redirects fetch on a mispredict. Optional counters: BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IDX_W = BRU_IDX_W,
  parameter  int PC_W  = BRU_PC_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [PC_W-1:0]  push_pc,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_pred_taken,
  input  logic [PC_W-1:0]  push_pred_target,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [PC_W-1:0]  upd_pc,
  output logic [IDX_W-1:0] upd_idx,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic [CW-1:0]    count,
  output logic             res_err,
`ifdef BRU_STATS_EN
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts,
`endif
  output logic             state_dbg
);
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [IDX_W-1:0] idx;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
  } entry_t;

  bru_state_e state, state_next;
  entry_t     push_entry, head;
  logic       fifo_full, fifo_empty, fifo_clear;
  logic       push_fire, pop_fire, mis_now;

  // Handshake: a push transfers on a cycle where push_valid && push_ready;
  // a resolve is consumed only in RUN with a non-empty queue.
  assign push_entry = '{pc: push_pc, idx: push_idx,
                        pred_taken: push_pred_taken, pred_target: push_pred_target};
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = res_valid && !fifo_empty && (state == RUN);
  assign mis_now    = (head.pred_taken != res_taken) ||
                      (res_taken && (head.pred_target != res_target));

  bru_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_fire),
    .pop       (pop_fire),
    .clear     (fifo_clear),
    .push_data (push_entry),
    .head_data (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (pop_fire && mis_now) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // The FLUSH cycle coincides with the registered mispredict pulse.
  always_comb begin
    push_ready = (state == RUN) && !fifo_full;
    flush      = (state == FLUSH);
    fifo_clear = (state == FLUSH);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_taken   <= 1'b0;
      upd_pc      <= '0;
      upd_idx     <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      res_err     <= 1'b0;
    end else begin
      upd_valid  <= pop_fire;
      mispredict <= pop_fire && mis_now;
      if (pop_fire) begin
        upd_taken <= res_taken;
        upd_pc    <= head.pc;
        upd_idx   <= head.idx;
      end
      if (pop_fire && mis_now)
        redirect_pc <= res_taken ? res_target : head.pc + PC_W'(PC_INCR);
      if (res_valid && fifo_empty && (state == RUN)) res_err <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: queue-based reference model
// feeds expected training/redirect responses to an independent monitor.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int EW    = 1 + 32 + 10 + 1 + 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        push_valid, push_ready, push_pred_taken;
  logic [31:0] push_pc, push_pred_target;
  logic [9:0]  push_idx;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        upd_valid, upd_taken, mispredict, flush, res_err, state_dbg;
  logic [31:0] upd_pc, redirect_pc;
  logic [9:0]  upd_idx;
  logic [2:0]  count;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(10), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_idx(push_idx), .push_pred_taken(push_pred_taken),
    .push_pred_target(push_pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
    .upd_idx(upd_idx), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .flush(flush), .count(count), .res_err(res_err),
`ifdef BRU_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .state_dbg(state_dbg)
  );

  // reference model state
  typedef struct {
    logic [31:0] pc;
    logic [9:0]  idx;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic [EW-1:0] exp_q[$];
  logic        m_flush = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_redirect = '0;
  int          m_branches = 0;
  int          m_mis = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at a negedge, applies one cycle of stimulus
  task automatic step(input logic pv, input logic [31:0] pc, input logic [9:0] idx,
                      input logic pt, input logic [31:0] ptgt,
                      input logic rv, input logic rt, input logic [31:0] rtgt);
    logic push_fire, pop_fire, mis, nxt_flush;
    ent_t e;
    chk("count", EW'(count), EW'(mq.size()));
    chk("push_ready", EW'(push_ready), EW'(!m_flush && mq.size() < DEPTH));
    chk("res_err", EW'(res_err), EW'(m_err));
    push_valid = pv; push_pc = pc; push_idx = idx;
    push_pred_taken = pt; push_pred_target = ptgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    push_fire = pv && !m_flush && (mq.size() < DEPTH);
    pop_fire  = rv && !m_flush && (mq.size() > 0);
    nxt_flush = 1'b0;
    if (pop_fire) begin
      e = mq.pop_front();
      mis = (e.pt != rt) || (rt && e.tgt != rtgt);
      if (mis) begin
        m_redirect = rt ? rtgt : e.pc + 32'd4;
        nxt_flush = 1'b1;
        m_mis++;
      end
      m_branches++;
      exp_q.push_back({rt, e.pc, e.idx, mis, m_redirect});
    end else if (rv && !m_flush) begin
      m_err = 1'b1;
    end
    if (push_fire) begin
      e.pc = pc; e.idx = idx; e.pt = pt; e.tgt = ptgt;
      mq.push_back(e);
    end
    if (m_flush) mq.delete();
    m_flush = nxt_flush;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // monitor: checks DUT responses against the scoreboard queue
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (rst_n) begin
      if (upd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_upd_valid", EW'(upd_valid), EW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("update", {upd_taken, upd_pc, upd_idx, mispredict, redirect_pc}, e);
          chk("flush", EW'(flush), EW'(e[32]));
        end
      end else begin
        chk("idle_mispredict", EW'(mispredict), EW'(0));
      end
    end
  end

  initial begin
    logic [31:0] r_tgt;
    logic        r_t;
    push_valid = 0; push_pc = 0; push_idx = 0; push_pred_taken = 0;
    push_pred_target = 0; res_valid = 0; res_taken = 0; res_target = 0;
    repeat (2) @(negedge clk);
    chk("rst_upd_valid", EW'(upd_valid), EW'(0));
    chk("rst_mispredict", EW'(mispredict), EW'(0));
    chk("rst_flush", EW'(flush), EW'(0));
    chk("rst_redirect", EW'(redirect_pc), EW'(0));
    chk("rst_upd_pc", EW'({upd_pc, upd_idx, upd_taken}), EW'(0));
    chk("rst_push_ready", EW'(push_ready), EW'(1));
    chk("rst_count", EW'(count), EW'(0));
    rst_n = 1'b1;

    // correct taken prediction
    step(1, 32'h100, 10'h3A, 1, 32'h180, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h180);
    idle();
    // direction mispredict, redirect to pc+4
    step(1, 32'h200, 10'h11, 1, 32'h280, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(); idle();
    // target mispredict
    step(1, 32'h2F0, 10'h22, 1, 32'h300, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h340);
    idle(); idle();
    // fill, full, simultaneous push+pop at count 3, drain across wrap
    for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(i*16), 10'(i), 0, 0, 0, 0, 0);
    step(1, 32'h4F0, 10'h3F, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 32'h500, 10'h50, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    // empty resolve
    step(0, 0, 0, 0, 0, 1, 1, 32'h44);
    idle(); idle();
    // reset during FLUSH
    step(1, 32'h600, 10'h60, 0, 0, 0, 0, 0);
    step(1, 32'h610, 10'h61, 0, 0, 1, 1, 32'h700);
    chk("flush_cycle", EW'(flush), EW'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", EW'({upd_valid, mispredict, flush, res_err, redirect_pc, count}), EW'(0));
    chk("midrst_push_ready", EW'(push_ready), EW'(1));
    mq.delete(); m_flush = 0; m_err = 0; m_redirect = 0; m_branches = 0; m_mis = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    // five resolves, two mispredicts
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h800 + 32'(i*8), 10'(i), 1, 32'h900, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 32'h900);
      idle();
    end
`ifdef BRU_STATS_EN
    idle();
    chk("stat_branches5", EW'(stat_branches), EW'(5));
    chk("stat_mispredicts2", EW'(stat_mispredicts), EW'(2));
`endif
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r_t = $urandom_range(0, 1);
      r_tgt = $urandom_range(0, 1) ? 32'h1000 : 32'h2000;
      if (mq.size() > 0 && $urandom_range(0, 99) < 65) begin
        r_t = mq[0].pt;
        r_tgt = mq[0].tgt;
      end
      step($urandom_range(0, 99) < 60, $urandom() & 32'hFFFF_FFFC, 10'($urandom()),
           1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 32'h1000 : 32'h2000,
           $urandom_range(0, 99) < 50, r_t, r_tgt);
    end
    repeat (4) idle();
    chk("exp_q_drained", EW'(exp_q.size()), EW'(0));
`ifdef BRU_STATS_EN
    chk("stat_branches", EW'(stat_branches), EW'(m_branches));
    chk("stat_mispredicts", EW'(stat_mispredicts), EW'(m_mis));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
